// File: rtl/rgb_sram_reader_pkg.sv
// Shared types and constants for the RGB frame reader.
// Frame geometry, SRAM base address and the reader state encoding.
package rgb_sram_reader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_ISSUE1,
        S_ISSUE2,
        S_HOLD,
        S_DRAIN
    } state_t;

    localparam logic [17:0] RGB_BASE_DEFAULT   = 18'd146944;
    localparam int unsigned NUM_PIXELS_DEFAULT = 76800;
    localparam int unsigned WORDS_PER_FRAME    = 115200;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 8;

    typedef struct packed {
        logic       last;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    // Which word of a 3-word pixel pair an issue state fetches.
    function automatic logic [1:0] issue_kind(state_t s);
        logic [1:0] k;
        k = 2'd0;
        if (s == S_ISSUE1) k = 2'd1;
        if (s == S_ISSUE2) k = 2'd2;
        return k;
    endfunction

endpackage

// File: rtl/rgb_sram_reader_pixel_fifo.sv
// Small synchronous FIFO holding unpacked pixels (colour + last flag).
// Head entry is presented straight from the storage registers.
module pixel_fifo #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned WIDTH      = 25,
    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign pop_data = mem[rd_ptr];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/rgb_sram_reader.sv
// Reads the interleaved RGB frame back from SRAM and streams it as
// 24-bit pixels in raster order over a valid/ready interface.
module rgb_sram_reader
    import rgb_sram_reader_pkg::*;
#(
    parameter logic [17:0] RGB_BASE   = RGB_BASE_DEFAULT,
    parameter int unsigned NUM_PIXELS = NUM_PIXELS_DEFAULT,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Start,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic [7:0]  pixel_R,
    output logic [7:0]  pixel_G,
    output logic [7:0]  pixel_B,
    output logic        pixel_last,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned WORDS = NUM_PIXELS * 3 / 2;
    localparam int unsigned WC_W  = $clog2(WORDS + 1);
    localparam int unsigned PC_W  = $clog2(NUM_PIXELS + 1);
    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

    state_t          state, state_nx;
    logic [WC_W-1:0] word_count;
    logic [PC_W-1:0] push_count;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   in_flight;
    logic            p1_v, p2_v;
    logic [1:0]      p1_k, p2_k;
    logic [7:0]      r0, g0, r1;
    logic            push, pop, issue;
    logic            credit, words_left, drain_done;
    pixel_t          push_px, pop_px;

    assign SRAM_write_data = 16'd0;
    assign SRAM_we_n       = 1'b1;
    assign busy            = (state != S_IDLE);

    // Reserve room for the pair about to be fetched before fetching it.
    assign credit = (int'(fifo_count) + int'(in_flight))
                    <= (int'(FIFO_DEPTH) - 2);
    assign words_left = (word_count != WC_W'(WORDS));
    assign drain_done = (fifo_count == '0) && (in_flight == '0);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (Start) state_nx = credit ? S_ISSUE0 : S_HOLD;
            S_ISSUE0: state_nx = S_ISSUE1;
            S_ISSUE1: state_nx = S_ISSUE2;
            S_ISSUE2: begin
                if (!words_left) state_nx = S_DRAIN;
                else if (credit) state_nx = S_ISSUE0;
                else             state_nx = S_HOLD;
            end
            S_HOLD:   if (credit) state_nx = S_ISSUE0;
            S_DRAIN:  if (drain_done) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    assign issue = (state_nx == S_ISSUE0) || (state_nx == S_ISSUE1)
                || (state_nx == S_ISSUE2);

    always_comb begin
        push    = p2_v && (p2_k != 2'd0);
        push_px = '0;
        push_px.last = (push_count == PC_W'(NUM_PIXELS - 1));
        if (p2_k == 2'd1) begin
            push_px.r = r0;
            push_px.g = g0;
            push_px.b = SRAM_read_data[15:8];
        end else begin
            push_px.r = r1;
            push_px.g = SRAM_read_data[15:8];
            push_px.b = SRAM_read_data[7:0];
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state        <= S_IDLE;
            SRAM_address <= '0;
            word_count   <= '0;
            push_count   <= '0;
            in_flight    <= '0;
            p1_v         <= 1'b0;
            p2_v         <= 1'b0;
            p1_k         <= 2'd0;
            p2_k         <= 2'd0;
            r0           <= '0;
            g0           <= '0;
            r1           <= '0;
            frame_done   <= 1'b0;
        end else begin
            state <= state_nx;
            if (issue) begin
                SRAM_address <= RGB_BASE + 18'(word_count);
                word_count   <= word_count + 1'b1;
            end else if (state == S_DRAIN && drain_done) begin
                word_count <= '0;
            end
            p1_v <= (issue_kind(state) != 2'd0) || (state == S_ISSUE0);
            p1_k <= issue_kind(state);
            p2_v <= p1_v;
            p2_k <= p1_k;
            if (p2_v && p2_k == 2'd0) begin
                r0 <= SRAM_read_data[15:8];
                g0 <= SRAM_read_data[7:0];
            end
            if (p2_v && p2_k == 2'd1) r1 <= SRAM_read_data[7:0];
            in_flight <= in_flight
                       + ((state == S_ISSUE0) ? CW'(2) : CW'(0))
                       - CW'(push);
            if (state == S_DRAIN && drain_done) push_count <= '0;
            else if (push)                      push_count <= push_count + 1'b1;
            frame_done <= (state == S_DRAIN) && drain_done;
        end
    end

    assign pixel_valid = (fifo_count != '0);
    assign pop         = pixel_valid && pixel_ready;
    assign pixel_last  = pop_px.last;
    assign pixel_R     = pop_px.r;
    assign pixel_G     = pop_px.g;
    assign pixel_B     = pop_px.b;

    pixel_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      ($bits(pixel_t))
    ) u_fifo (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .push      (push),
        .push_data (push_px),
        .pop       (pop),
        .pop_data  (pop_px),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_rgb_sram_reader.sv
// Scoreboard bench for rgb_sram_reader: a short frame placed at the top of
// SRAM so the final word sits at address 262143.
module tb_rgb_sram_reader;

    localparam int          NP   = 1200;
    localparam int          NW   = NP * 3 / 2;
    localparam int          FD   = 8;
    localparam logic [17:0] BASE = 18'd260344;
    localparam logic [17:0] LAST = 18'd262143;

    logic        Clock;
    logic        Resetn;
    logic        Start;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [7:0]  pixel_R, pixel_G, pixel_B;
    logic        pixel_last;
    logic        busy;
    logic        frame_done;

    rgb_sram_reader #(
        .RGB_BASE   (BASE),
        .NUM_PIXELS (NP),
        .FIFO_DEPTH (FD)
    ) dut (
        .Clock           (Clock),
        .Resetn          (Resetn),
        .Start           (Start),
        .SRAM_address    (SRAM_address),
        .SRAM_read_data  (SRAM_read_data),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .pixel_valid     (pixel_valid),
        .pixel_ready     (pixel_ready),
        .pixel_R         (pixel_R),
        .pixel_G         (pixel_G),
        .pixel_B         (pixel_B),
        .pixel_last      (pixel_last),
        .busy            (busy),
        .frame_done      (frame_done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    logic [15:0] mem [NW];
    logic [15:0] rd_d1;

    function automatic logic [15:0] sram_word(logic [17:0] a);
        int idx;
        idx = int'(a) - int'(BASE);
        if (idx < 0 || idx >= NW) return 16'hDEAD;
        return mem[idx];
    endfunction

    // Two-cycle read latency SRAM model.
    always @(posedge Clock) begin
        rd_d1          <= sram_word(SRAM_address);
        SRAM_read_data <= rd_d1;
    end

    function automatic logic [24:0] exp_pixel(int i);
        logic [15:0] w0, w1, w2;
        logic        l;
        w0 = mem[3 * (i / 2)];
        w1 = mem[3 * (i / 2) + 1];
        w2 = mem[3 * (i / 2) + 2];
        l  = (i == NP - 1);
        if (i % 2 == 0) return {l, w0[15:8], w0[7:0], w1[15:8]};
        return {l, w1[7:0], w2[15:8], w2[7:0]};
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    logic [24:0] exp_q [$];
    int          n_acc    = 0;
    int          n_done   = 0;
    int          last_cyc = 0;
    int          done_cyc = 0;
    logic        stall    = 1'b0;
    logic [24:0] stall_px = '0;

    // Monitor: compares every accepted pixel against the scoreboard.
    always @(negedge Clock) begin
        logic [24:0] act;
        logic [24:0] e;
        act = {pixel_last, pixel_R, pixel_G, pixel_B};
        if (!Resetn) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("hold_valid", 32'(pixel_valid), 32'd1);
                check("hold_data", 32'(act), 32'(stall_px));
            end
            if (pixel_valid && pixel_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", 32'(act), 32'h1FFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("pixel%0d", n_acc), 32'(act), 32'(e));
                end
                if (pixel_last) last_cyc = cyc;
                n_acc++;
            end
            stall    = pixel_valid && !pixel_ready;
            stall_px = act;
            if (frame_done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    int acc0 = 0;
    int d0   = 0;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic start_frame();
        for (int i = 0; i < NP; i++) exp_q.push_back(exp_pixel(i));
        acc0  = n_acc;
        d0    = n_done;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_done(string tag, int bound, bit rnd);
        int k;
        for (k = 0; k < bound; k++) begin
            if (n_done > d0) break;
            if (rnd) pixel_ready = 1'($urandom_range(0, 1));
            tick();
        end
        pixel_ready = 1'b1;
        repeat (4) tick();
        check({tag, "_done_pulses"}, 32'(n_done - d0), 32'd1);
        check({tag, "_pixels"}, 32'(n_acc - acc0), 32'(NP));
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_last_addr"}, 32'(SRAM_address), 32'(LAST));
        check({tag, "_done_delay"},
              32'((done_cyc - last_cyc) inside {1, 2}), 32'd1);
        exp_q.delete();
    endtask

    task automatic check_reset(string tag);
        check({tag, "_addr"}, 32'(SRAM_address), 32'd0);
        check({tag, "_wdata"}, 32'(SRAM_write_data), 32'd0);
        check({tag, "_we_n"}, 32'(SRAM_we_n), 32'd1);
        check({tag, "_valid"}, 32'(pixel_valid), 32'd0);
        check({tag, "_rgb"}, 32'({pixel_R, pixel_G, pixel_B}), 32'd0);
        check({tag, "_last"}, 32'(pixel_last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        Resetn      = 1'b0;
        Start       = 1'b0;
        pixel_ready = 1'b1;
        for (int i = 0; i < NW; i++) mem[i] = 16'((i * 40503 + 7) ^ (i >> 3));
        mem[0] = 16'h1122;
        mem[1] = 16'h3344;
        mem[2] = 16'h5566;

        repeat (3) tick();
        check_reset("por");
        Resetn = 1'b1;
        tick();

        // Frame A: latency, first pixels, Start while busy, full frame.
        start_frame();
        check("a_addr_c1", 32'(SRAM_address), 32'(BASE));
        check("a_busy_c1", 32'(busy), 32'd1);
        tick();
        check("a_addr_c2", 32'(SRAM_address), 32'(BASE + 18'd1));
        tick();
        check("a_addr_c3", 32'(SRAM_address), 32'(BASE + 18'd2));
        tick();
        check("a_valid_c4", 32'(pixel_valid), 32'd0);
        tick();
        check("a_valid_c5", 32'(pixel_valid), 32'd1);
        check("a_px_c5", 32'({pixel_R, pixel_G, pixel_B}), 32'h112233);
        tick();
        check("a_valid_c6", 32'(pixel_valid), 32'd1);
        check("a_px_c6", 32'({pixel_R, pixel_G, pixel_B}), 32'h445566);
        repeat (100) tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("a_we_n_busy", 32'(SRAM_we_n), 32'd1);
        wait_done("a", 4000, 1'b0);

        // Frame B: consumer stalled for 50 cycles after Start.
        pixel_ready = 1'b0;
        start_frame();
        repeat (49) tick();
        check("b_stall_addr", 32'(SRAM_address), 32'(BASE + 18'(FD * 3 / 2 - 1)));
        check("b_stall_valid", 32'(pixel_valid), 32'd1);
        check("b_stall_acc", 32'(n_acc - acc0), 32'd0);
        pixel_ready = 1'b1;
        wait_done("b", 4000, 1'b0);

        // Frame C: random back-pressure.
        start_frame();
        wait_done("c", 10000, 1'b1);

        // Frame D: reset mid-frame, then restart from pixel 0.
        start_frame();
        for (int k = 0; k < 3000; k++) begin
            if (n_acc - acc0 >= 1000) break;
            tick();
        end
        check("d_reached_1000", 32'(n_acc - acc0 >= 1000), 32'd1);
        Resetn = 1'b0;
        #1;
        check_reset("mid");
        exp_q.delete();
        repeat (3) tick();
        Resetn = 1'b1;
        tick();
        start_frame();
        check("d_restart_addr", 32'(SRAM_address), 32'(BASE));
        wait_done("d", 4000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_sram_reader.md
# rgb_sram_reader

Downstream stage of the YUV-to-RGB colour-space converter: after that stage has written the 320x240 RGB frame to external SRAM, this block reads the interleaved RGB words back, unpacks them into 24-bit pixels and streams them in raster order over a valid/ready interface to the display controller. It owns the SRAM port only while busy; the top level muxes SRAM ownership between the converter and this block.

## Interface
- RGB_BASE, 18'd146944, word address of the first RGB word
- NUM_PIXELS, 76800, pixels per frame (even; 320x240)
- FIFO_DEPTH, 8, pixel FIFO depth (power of two, >= 4)
- Clock  input  1  system clock; all logic on rising edge
- Resetn  input  1  asynchronous, active-low reset
- Start  input  1  one-cycle pulse; begins a frame read when idle
- SRAM_address  output  18  read address
- SRAM_read_data  input  16  SRAM read data
- SRAM_write_data  output  16  constant 16'd0
- SRAM_we_n  output  1  constant 1 while out of reset (read-only block)
- pixel_valid  output  1  pixel_R/G/B hold a valid pixel
- pixel_ready  input  1  consumer accepts pixel this cycle
- pixel_R, pixel_G, pixel_B  output  8 each  pixel colour
- pixel_last  output  1  qualifies pixel NUM_PIXELS-1
- busy  output  1  frame read in progress
- frame_done  output  1  one-cycle pulse after last pixel accepted

## Operation
- Memory format: two pixels per three words: w0={R0,G0}, w1={B0,R1}, w2={G1,B1} (high byte first). Word address = RGB_BASE + word_count, word_count 0..(NUM_PIXELS*3/2-1); last address 262143, no wrap.
- States: IDLE, ISSUE0, ISSUE1, ISSUE2, HOLD, DRAIN.
- IDLE: on Start -> ISSUE0 (if credit available, else HOLD); busy=1. Start ignored when busy.
- ISSUE0/1/2: drive successive addresses, word_count+1 each. After ISSUE2: if words remain and credit -> ISSUE0; words remain, no credit -> HOLD; none remain -> DRAIN.
- Credit: fifo_count + pixels_in_flight <= FIFO_DEPTH-2, evaluated in the cycle before ISSUE0. pixels_in_flight counts issued-but-not-pushed pixels.
- HOLD: wait for credit -> ISSUE0.
- Unpack: w0 captured to R0/G0 holding regs; w1 arrival pushes {R0,G0,B0}, holds R1; w2 arrival pushes {R1,G1,B1}.
- DRAIN: when FIFO empty and no reads in flight -> IDLE, busy=0, frame_done=1 for one cycle.
- Stream: pixel held stable while pixel_valid && !pixel_ready; transfer on valid&&ready. pixel_last set on pixel index NUM_PIXELS-1 only.
- FIFO never overflows (credit guarantees it); push and pop in the same cycle leave count unchanged; pop when empty impossible (valid=0).

## Timing
- SRAM read latency 2: data for address driven in cycle c valid in cycle c+2, captured at end of c+2.
- Start in cycle 0: RGB_BASE driven cycle 1, +1 cycle 2, +2 cycle 3; pixel 0 pushed end of cycle 4, pixel_valid=1 in cycle 5.
- Peak throughput 2 pixels / 3 cycles with pixel_ready held high.
- Reset values: SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1, pixel_valid=0, pixel_R/G/B=0, pixel_last=0, busy=0, frame_done=0, state IDLE, counters and FIFO cleared.
- Resetn asserted mid-frame: all of the above immediately; in-flight read data discarded; next Start restarts at pixel 0.

## Structure
- Shared package: state enum typedef, RGB_BASE, NUM_PIXELS, words-per-frame constant (115200).
- Sub-module pixel_fifo: synchronous 24+1-bit FIFO (colour + last), registered output, count output, parameter FIFO_DEPTH.

## Test plan
- Reset, then Start with SRAM preloaded w0=16'h1122, w1=16'h3344, w2=16'h5566, pixel_ready=1 -> cycle 5 pixel (11,22,33), cycle 6 pixel (44,55,66), first address 146944.
- Full frame with pixel_ready=1 -> exactly 76800 pixels, pixel_last on final one only, last address 262143, frame_done one cycle later, busy falls.
- pixel_ready=0 for 50 cycles after Start -> addresses stop after FIFO_DEPTH pixels committed, pixel data stable, no pixel lost or duplicated when ready returns.
- Random pixel_ready toggling over full frame -> output sequence equals model unpacking of SRAM contents.
- Start pulsed while busy -> ignored, frame unaffected.
- Resetn low at pixel 1000 -> outputs at reset values at once; new Start streams from pixel 0 at 146944.
